// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8-bit UART transmitter (start, 8 data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int DEFAULT_DIV = 106
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       cfg_div_we,
    input  logic [31:0]                cfg_div_di,
    output logic [31:0]                cfg_div_do,
    input  logic                       dat_we,
    input  logic [7:0]                 dat_di,
    output logic                       dat_wait,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full, empty, push, pop;

    state_t        state_q, state_d;
    logic [31:0]   div_q, div_d;
    logic [31:0]   divl_q, divl_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [2:0]    bidx_q, bidx_d;
    logic [7:0]    shf_q, shf_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          start_frame;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    assign full       = (level_q == FULL_LVL);
    assign empty      = (level_q == '0);
    assign push       = dat_we & ~full;
    assign dat_wait   = dat_we & full;
    assign fifo_level = level_q;
    assign cfg_div_do = div_q;
    assign tx         = tx_q;
    assign busy       = ~empty | (state_q != IDLE);
    assign bit_end    = (cnt_q == divl_q - 32'd1);

    always_comb begin
        div_d = div_q;
        if (cfg_div_we) begin
            div_d = (cfg_div_di < 32'd2) ? 32'd2 : cfg_div_di;
        end
    end

    // FIFO bookkeeping; a simultaneous push and pop leaves the level unchanged
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        divl_d      = divl_q;
        bidx_d      = bidx_q;
        shf_d       = shf_q;
        tx_d        = tx_q;
        pop         = 1'b0;
        start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    start_frame = 1'b1;
                end
            end
            START: begin
                cnt_d = bit_end ? 32'd0 : cnt_q + 32'd1;
                if (bit_end) begin
                    state_d = DATA;
                    bidx_d  = 3'd0;
                    tx_d    = shf_q[0];
                end
            end
            DATA: begin
                cnt_d = bit_end ? 32'd0 : cnt_q + 32'd1;
                if (bit_end) begin
                    if (bidx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                        shf_d  = shf_q >> 1;
                        tx_d   = shf_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                cnt_d = bit_end ? 32'd0 : cnt_q + 32'd1;
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                cnt_d = bit_end ? 32'd0 : cnt_q + 32'd1;
                if (bit_end) begin
                    if (!empty) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start pops the head and latches the divider for the whole frame
        if (start_frame) begin
            pop     = 1'b1;
            state_d = START;
            cnt_d   = 32'd0;
            divl_d  = div_q;
            shf_d   = mem_q[rptr_q];
            tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem_q[rptr_q];
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            state_q <= IDLE;
            div_q   <= 32'(DEFAULT_DIV);
            divl_q  <= 32'(DEFAULT_DIV);
            cnt_q   <= 32'd0;
            bidx_q  <= 3'd0;
            tx_q    <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            state_q <= state_d;
            div_q   <= div_d;
            divl_q  <= divl_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            tx_q    <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= dat_di;
        end
        shf_q <= shf_d;
`ifdef UART_TX_PARITY_EN
        par_q <= par_d;
`endif
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single-frame vectors plus
// hand-written sequences for back-to-back frames, back-pressure, reset abort and divider changes.
module tb_uart_tx_fifo;

`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        cfg_div_we;
    logic [31:0] cfg_div_di;
    logic [31:0] cfg_div_do;
    logic        dat_we;
    logic [7:0]  dat_di;
    logic        dat_wait;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_level;

    uart_tx_fifo #(.DEPTH(16), .DEFAULT_DIV(106)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cfg_div_we (cfg_div_we),
        .cfg_div_di (cfg_div_di),
        .cfg_div_do (cfg_div_do),
        .dat_we     (dat_we),
        .dat_di     (dat_di),
        .dat_wait   (dat_wait),
        .tx         (tx),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [7:0] data;
        int         div;
        logic [9:0] frame;   // bit0 = start, bits 8:1 = data LSB first, bit9 = stop
        logic       par;     // even parity of data
    } vec_t;

    vec_t tbl [6];

    logic [32:0] cap_bits;
    bit          cap_stable;

    bit          mon_en  = 1'b0;
    int          mon_div = 106;
    int          rx_err  = 0;
    logic [7:0]  rx_q [$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    function automatic logic [32:0] frame_of(input logic [7:0] d);
        logic [32:0] f;
        f      = '0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
        f[10]  = 1'b1;
`else
        f[9]   = 1'b1;
`endif
        return f;
    endfunction

    task automatic set_div(input logic [31:0] v);
        cfg_div_we = 1'b1;
        cfg_div_di = v;
        @(negedge clk);
        cfg_div_we = 1'b0;
    endtask

    task automatic push_one(input logic [7:0] b);
        dat_we = 1'b1;
        dat_di = b;
        @(negedge clk);
        dat_we = 1'b0;
    endtask

    task automatic wait_tx_low(input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Samples tx every cycle from the current negedge; each bit must hold for exactly div cycles.
    task automatic capture(input int div, input int nbits, output logic [32:0] bits, output bit stable);
        bits   = '0;
        stable = 1'b1;
        for (int c = 0; c < div * nbits; c++) begin
            if (c > 0) @(negedge clk);
            if (c % div == 0) bits[c / div] = tx;
            else if (tx !== bits[c / div]) stable = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                if (tx !== 1'b0) rx_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    d[i] = tx;
                end
`ifdef UART_TX_PARITY_EN
                repeat (mon_div) @(negedge clk);
                if (tx !== ^d) rx_err++;
`endif
                repeat (mon_div) @(negedge clk);
                if (tx !== 1'b1) rx_err++;
                rx_q.push_back(d);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          found;
        logic [32:0] exp;
        int          first_wait;
        int          peak;
        int          guard;
        int          lows;

        tbl[0] = '{data: 8'h55, div: 3, frame: 10'b1010101010, par: 1'b0};
        tbl[1] = '{data: 8'hA3, div: 4, frame: 10'b1101000110, par: 1'b0};
        tbl[2] = '{data: 8'h00, div: 2, frame: 10'b1000000000, par: 1'b0};
        tbl[3] = '{data: 8'hFF, div: 2, frame: 10'b1111111110, par: 1'b0};
        tbl[4] = '{data: 8'h80, div: 5, frame: 10'b1100000000, par: 1'b1};
        tbl[5] = '{data: 8'h01, div: 7, frame: 10'b1000000010, par: 1'b1};

        resetn     = 1'b0;
        cfg_div_we = 1'b0;
        cfg_div_di = '0;
        dat_we     = 1'b0;
        dat_di     = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_wait", dat_wait, 0);
        check("rst_div", cfg_div_do, 106);

        // Write on the first edge after release; 0x55 at div 106
        resetn = 1'b1;
        dat_we = 1'b1;
        dat_di = 8'h55;
        @(negedge clk);
        dat_we = 1'b0;
        check("first_write_level", fifo_level, 1);
        check("tx_high_after_accept", tx, 1);
        @(negedge clk);
        check("tx_fall_2nd_edge", tx, 0);
        check("level_after_pop", fifo_level, 0);
        capture(106, NB, cap_bits, cap_stable);
        check("f55_bits", cap_bits, frame_of(8'h55));
        check("f55_stable", cap_stable, 1);
        check("f55_busy_last", busy, 1);
        @(negedge clk);
        check("f55_busy_drop", busy, 0);
        check("f55_tx_idle", tx, 1);

        for (int k = 0; k < 6; k++) begin
            set_div(tbl[k].div);
            check($sformatf("tbl%0d_div", k), cfg_div_do, tbl[k].div);
            push_one(tbl[k].data);
            wait_tx_low(10, found);
            if (!found) begin
                timeout($sformatf("tbl%0d_start", k));
            end else begin
`ifdef UART_TX_PARITY_EN
                exp = {22'b0, 1'b1, tbl[k].par, tbl[k].frame[8:0]};
`else
                exp = {23'b0, tbl[k].frame};
`endif
                capture(tbl[k].div, NB, cap_bits, cap_stable);
                check($sformatf("tbl%0d_bits", k), cap_bits, exp);
                check($sformatf("tbl%0d_stable", k), cap_stable, 1);
                check($sformatf("tbl%0d_busy_last", k), busy, 1);
                @(negedge clk);
                check($sformatf("tbl%0d_busy_drop", k), busy, 0);
            end
        end

        // Three contiguous frames, decoded by the half-period sampler too
        set_div(106);
        mon_div = 106;
        rx_q.delete();
        rx_err = 0;
        mon_en = 1'b1;
        dat_we = 1'b1;
        dat_di = 8'h48;
        @(negedge clk);
        dat_di = 8'h69;
        @(negedge clk);
        dat_di = 8'h0A;
        check("hi_tx_start", tx, 0);
        fork
            capture(106, 3 * NB, cap_bits, cap_stable);
            begin
                @(negedge clk);
                dat_we = 1'b0;
            end
        join
        exp = frame_of(8'h48) | (frame_of(8'h69) << NB) | (frame_of(8'h0A) << (2 * NB));
        check("hi_bits", cap_bits, exp);
        check("hi_stable", cap_stable, 1);
        @(negedge clk);
        check("hi_busy_drop", busy, 0);
        mon_en = 1'b0;
        check("hi_rx_count", rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check("hi_rx0", rx_q[0], 8'h48);
            check("hi_rx1", rx_q[1], 8'h69);
            check("hi_rx2", rx_q[2], 8'h0A);
        end
        check("hi_rx_err", rx_err, 0);

        // Back-pressure: 20 bytes into a 16-deep FIFO
        set_div(4);
        mon_div = 4;
        rx_q.delete();
        rx_err = 0;
        mon_en = 1'b1;
        first_wait = -1;
        peak = 0;
        for (int b = 0; b < 20; b++) begin
            dat_we = 1'b1;
            dat_di = 8'(b);
            #1;
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
            guard = 0;
            while (dat_wait === 1'b1 && guard < 200) begin
                if (first_wait < 0) first_wait = b;
                @(negedge clk);
                #1;
                guard++;
            end
            if (guard >= 200) timeout($sformatf("bp_wait_byte%0d", b));
            @(negedge clk);
        end
        dat_we = 1'b0;
        check("bp_first_wait", first_wait, 8'h11);
        check("bp_peak", peak, 16);
        guard = 0;
        while (busy === 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) timeout("bp_drain");
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        check("bp_rx_count", rx_q.size(), 20);
        for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
            check($sformatf("bp_rx%0d", i), rx_q[i], 8'(i));
        end
        check("bp_rx_err", rx_err, 0);

        // Divider clamp and mid-frame divider change
        set_div(0);
        check("clamp0", cfg_div_do, 2);
        set_div(1);
        check("clamp1", cfg_div_do, 2);
        dat_we = 1'b1;
        dat_di = 8'hFF;
        @(negedge clk);
        dat_di = 8'h3C;
        @(negedge clk);
        dat_we = 1'b0;
        wait_tx_low(10, found);
        if (!found) begin
            timeout("div_start");
        end else begin
            fork
                capture(2, NB, cap_bits, cap_stable);
                begin
                    repeat (5) @(negedge clk);
                    set_div(50);
                end
            join
            check("div2_bits", cap_bits, frame_of(8'hFF));
            check("div2_stable", cap_stable, 1);
            check("div_readback50", cfg_div_do, 50);
            @(negedge clk);
            capture(50, NB, cap_bits, cap_stable);
            check("div50_bits", cap_bits, frame_of(8'h3C));
            check("div50_stable", cap_stable, 1);
            @(negedge clk);
            check("div50_busy_drop", busy, 0);
        end

`ifdef UART_TX_PARITY_EN
        set_div(4);
        push_one(8'h07);
        wait_tx_low(10, found);
        if (!found) timeout("par07_start");
        else begin
            capture(4, 11, cap_bits, cap_stable);
            check("par07_bit", cap_bits[9], 1);
            check("par07_bits", cap_bits, {22'b0, 11'b11000001110});
            check("par07_stable", cap_stable, 1);
            @(negedge clk);
            check("par07_busy_drop", busy, 0);
        end
        push_one(8'h03);
        wait_tx_low(10, found);
        if (!found) timeout("par03_start");
        else begin
            capture(4, 11, cap_bits, cap_stable);
            check("par03_bit", cap_bits[9], 0);
            check("par03_bits", cap_bits, {22'b0, 11'b10000000110});
            check("par03_stable", cap_stable, 1);
            @(negedge clk);
            check("par03_busy_drop", busy, 0);
        end
`endif

        // Reset in the middle of data bit 3 of 0xA3 with 5 bytes still queued
        set_div(8);
        dat_we = 1'b1;
        dat_di = 8'hA3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dat_di = 8'h11 + 8'(i);
        end
        @(negedge clk);
        dat_we = 1'b0;
        check("abort_level_before", fifo_level, 5);
        repeat (29) @(negedge clk);
        check("abort_tx_before", tx, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_level", fifo_level, 0);
        check("abort_busy", busy, 0);
        check("abort_wait", dat_wait, 0);
        check("abort_div", cfg_div_do, 106);
        @(negedge clk);
        resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        check("abort_quiet", lows, 0);
        check("abort_level_after", fifo_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
